// File: rtl/alu_exec_ctrl_if.sv
//==========================================================================
// alu_exec_ctrl_if : decode/ALU/write-back bundle for alu_exec_ctrl. Rev 1.0
//==========================================================================
`default_nettype none

interface alu_exec_ctrl_if #(
  parameter int DW = 32,
  parameter int RW = 4
) ();
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cond;
  logic [3:0]    req_opcode;
  logic          req_s;
  logic [RW-1:0] req_rd;
  logic [DW-1:0] req_rn;
  logic [DW-1:0] req_shop;
  logic          req_shc;
  logic [4:0]    alu_op;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic          alu_cin;
  logic [DW-1:0] alu_r;
  logic [3:0]    alu_flag;
  logic          flag_we;
  logic [3:0]    flag_wdata;
  logic [3:0]    flags;
  logic          wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          skip;

  modport slave (
    input  req_valid, req_cond, req_opcode, req_s, req_rd, req_rn, req_shop, req_shc,
    input  alu_r, alu_flag, flag_we, flag_wdata,
    output req_ready, alu_op, alu_a, alu_b, alu_cin, flags, wb_valid, wb_rd, wb_data, skip
  );

  modport master (
    output req_valid, req_cond, req_opcode, req_s, req_rd, req_rn, req_shop, req_shc,
    output alu_r, alu_flag, flag_we, flag_wdata,
    input  req_ready, alu_op, alu_a, alu_b, alu_cin, flags, wb_valid, wb_rd, wb_data, skip
  );
endinterface

`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
//==========================================================================
// alu_exec_ctrl : ARM data-processing execute sequencer (IDLE/EVAL/EXEC/WB).
// Macro ALU_COND_EXEC_EN enables condition-code evaluation and skip. Rev 1.0
//==========================================================================
`default_nettype none

module alu_exec_ctrl #(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    op_q;
  logic          s_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] rn_q;
  logic [DW-1:0] shop_q;
  logic          shc_q;
  logic [4:0]    alu_op_q;
  logic [DW-1:0] alu_a_q;
  logic [DW-1:0] alu_b_q;
  logic          alu_cin_q;
  logic [3:0]    flags_q;
  logic          wb_valid_q;
  logic [RW-1:0] wb_rd_q;
  logic [DW-1:0] wb_data_q;
  logic          cond_pass;
  logic          is_cmp;
  logic          is_arith;
  logic [3:0]    flags_upd;

  // Compare class is 10xx; arithmetic is 001x, 01xx and 101x.
  assign is_cmp   = (op_q[3:2] == 2'b10);
  assign is_arith = (op_q[3:2] == 2'b01) || (op_q[3:1] == 3'b001) || (op_q[3:1] == 3'b101);
  assign flags_upd = is_arith ? bus.alu_flag
                              : {shc_q, bus.alu_flag[2], flags_q[1], bus.alu_flag[0]};

`ifdef ALU_COND_EXEC_EN
  logic [3:0] cond_q;
  logic       skip_q;

  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
    logic fc, fz, fv, fn;
    fc = f[3];
    fz = f[2];
    fv = f[1];
    fn = f[0];
    case (c)
      4'h0:    cond_ok = fz;
      4'h1:    cond_ok = !fz;
      4'h2:    cond_ok = fc;
      4'h3:    cond_ok = !fc;
      4'h4:    cond_ok = fn;
      4'h5:    cond_ok = !fn;
      4'h6:    cond_ok = fv;
      4'h7:    cond_ok = !fv;
      4'h8:    cond_ok = fc && !fz;
      4'h9:    cond_ok = !fc || fz;
      4'hA:    cond_ok = (fn == fv);
      4'hB:    cond_ok = (fn != fv);
      4'hC:    cond_ok = !fz && (fn == fv);
      4'hD:    cond_ok = fz || (fn != fv);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  endfunction

  assign cond_pass = cond_ok(cond_q, flags_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cond_q <= 4'd0;
      skip_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid) cond_q <= bus.req_cond;
      skip_q <= (state_q == S_EVAL) && !cond_pass;
    end
  end

  assign bus.skip = skip_q;
`else
  assign cond_pass = 1'b1;
  assign bus.skip  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_EVAL;
      S_EVAL:  state_d = cond_pass ? S_EXEC : S_IDLE;
      S_EXEC:  state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 4'd0;
      s_q        <= 1'b0;
      rd_q       <= '0;
      rn_q       <= '0;
      shop_q     <= '0;
      shc_q      <= 1'b0;
      alu_op_q   <= 5'd0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_cin_q  <= 1'b0;
      flags_q    <= 4'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      if (state_q == S_IDLE && bus.req_valid) begin
        op_q   <= bus.req_opcode;
        s_q    <= bus.req_s;
        rd_q   <= bus.req_rd;
        rn_q   <= bus.req_rn;
        shop_q <= bus.req_shop;
        shc_q  <= bus.req_shc;
      end
      if (state_q == S_EVAL && cond_pass) begin
        alu_op_q  <= {1'b0, op_q};
        alu_a_q   <= shop_q;
        alu_b_q   <= rn_q;
        alu_cin_q <= flags_q[3];
      end
      if (state_q == S_EXEC) begin
        wb_data_q  <= bus.alu_r;
        wb_rd_q    <= rd_q;
        wb_valid_q <= !is_cmp;
      end
      // The instruction's own flag update outranks a simultaneous MSR write.
      if (state_q == S_EXEC && (s_q || is_cmp)) flags_q <= flags_upd;
      else if (bus.flag_we)                     flags_q <= bus.flag_wdata;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.alu_op    = alu_op_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_cin   = alu_cin_q;
  assign bus.flags     = flags_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
//==========================================================================
// tb_alu_exec_ctrl : table-driven bench with a behavioural ARM ALU. Rev 1.0
//==========================================================================
`default_nettype none

module tb_alu_exec_ctrl;

`ifdef ALU_COND_EXEC_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_exec_ctrl_if #(.DW(32), .RW(4)) bus ();

  alu_exec_ctrl #(.DW(32), .RW(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: A = shifter operand, B = Rn, flags {C,Z,V,N}.
  always_comb begin
    logic [31:0] x, y, r;
    logic [32:0] sum;
    logic        c0, cf, vf, arith;
    x = bus.alu_a; y = bus.alu_b; c0 = 1'b0; arith = 1'b1; r = 32'd0;
    case (bus.alu_op[3:0])
      4'h2, 4'hA: begin x = bus.alu_b; y = ~bus.alu_a; c0 = 1'b1; end
      4'h3:       begin y = ~bus.alu_b; c0 = 1'b1; end
      4'h5:       c0 = bus.alu_cin;
      4'h6:       begin x = bus.alu_b; y = ~bus.alu_a; c0 = bus.alu_cin; end
      4'h7:       begin y = ~bus.alu_b; c0 = bus.alu_cin; end
      4'h4, 4'hB: c0 = 1'b0;
      default:    arith = 1'b0;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {32'd0, c0};
    cf = 1'b0; vf = 1'b0;
    if (arith) begin
      r  = sum[31:0];
      cf = sum[32];
      vf = (x[31] == y[31]) && (sum[31] != x[31]);
    end else begin
      case (bus.alu_op[3:0])
        4'h0, 4'h8: r = bus.alu_a & bus.alu_b;
        4'h1, 4'h9: r = bus.alu_a ^ bus.alu_b;
        4'hC:       r = bus.alu_a | bus.alu_b;
        4'hD:       r = bus.alu_a;
        4'hE:       r = bus.alu_b & ~bus.alu_a;
        default:    r = ~bus.alu_a;
      endcase
    end
    bus.alu_r    = r;
    bus.alu_flag = {cf, (r == 32'd0), vf, r[31]};
  end

  typedef struct {
    logic [3:0]  cond;
    logic [3:0]  op;
    logic        s;
    logic [3:0]  rd;
    logic [31:0] rn;
    logic [31:0] shop;
    logic        shc;
    logic        skip;
    logic        wb;
    logic [31:0] data;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic offer(input logic [3:0] cond, input logic [3:0] op, input logic s,
                       input logic [3:0] rd, input logic [31:0] rn,
                       input logic [31:0] shop, input logic shc);
    wait_ready();
    bus.req_cond = cond; bus.req_opcode = op; bus.req_s = s; bus.req_rd = rd;
    bus.req_rn = rn; bus.req_shop = shop; bus.req_shc = shc;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input logic [3:0] prev);
    offer(v.cond, v.op, v.s, v.rd, v.rn, v.shop, v.shc);
    check("eval_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("c2_skip", 32'(bus.skip), 32'(v.skip));
    check("c2_wb_valid", 32'(bus.wb_valid), 32'd0);
    if (v.skip) begin
      check("skip_ready", 32'(bus.req_ready), 32'd1);
      check("skip_flags", 32'(bus.flags), 32'(prev));
      @(negedge clk);
      check("skip_pulse_end", 32'(bus.skip), 32'd0);
      check("skip_no_wb", 32'(bus.wb_valid), 32'd0);
    end else begin
      check("exec_alu_op", 32'(bus.alu_op), {27'd0, 1'b0, v.op});
      check("exec_alu_a", bus.alu_a, v.shop);
      check("exec_alu_b", bus.alu_b, v.rn);
      check("exec_alu_cin", 32'(bus.alu_cin), 32'(prev[3]));
      @(negedge clk);
      check("wb_valid", 32'(bus.wb_valid), 32'(v.wb));
      if (v.wb) begin
        check("wb_rd", 32'(bus.wb_rd), 32'(v.rd));
        check("wb_data", bus.wb_data, v.data);
      end
      check("flags", 32'(bus.flags), 32'(v.flags));
      @(negedge clk);
      check("wb_strobe_end", 32'(bus.wb_valid), 32'd0);
      check("ready_again", 32'(bus.req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0;
    //          cond   op    s     rd    rn             shop           shc   skip      wb        data            flags
    vecs[0] = '{4'hE, 4'h4, 1'b1, 4'd1, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b0,     1'b1,     32'h8000_0000,  4'b0011};
    vecs[1] = '{4'hE, 4'hA, 1'b0, 4'd2, 32'h5,          32'h5,         1'b0, 1'b0,     1'b0,     32'h0,          4'b1100};
    vecs[2] = '{4'h0, 4'h4, 1'b0, 4'd3, 32'h3,          32'h2,         1'b0, 1'b0,     1'b1,     32'h5,          4'b1100};
    vecs[3] = '{4'hE, 4'h4, 1'b1, 4'd2, 32'h1,          32'h7FFF_FFFF, 1'b0, 1'b0,     1'b1,     32'h8000_0000,  4'b0011};
    vecs[4] = '{4'h0, 4'hD, 1'b0, 4'd4, 32'h0,          32'h1234,      1'b0, COND_EN,  !COND_EN, 32'h1234,       4'b0011};
    vecs[5] = '{4'hE, 4'hD, 1'b1, 4'd5, 32'h0,          32'h0,         1'b1, 1'b0,     1'b1,     32'h0,          4'b1110};
    vecs[6] = '{4'hB, 4'h2, 1'b1, 4'd6, 32'd10,         32'd3,         1'b0, 1'b0,     1'b1,     32'd7,          4'b1000};
    vecs[7] = '{4'hF, 4'hD, 1'b0, 4'd7, 32'h0,          32'h9,         1'b0, COND_EN,  !COND_EN, 32'h9,          4'b1000};
    vecs[8] = '{4'hE, 4'h1, 1'b1, 4'd8, 32'hFF,         32'hF0,        1'b0, 1'b0,     1'b1,     32'h0F,         4'b0000};
    vecs[9] = '{4'hE, 4'h8, 1'b0, 4'd9, 32'h2,          32'h1,         1'b1, 1'b0,     1'b0,     32'h0,          4'b1100};

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_cond = 4'd0; bus.req_opcode = 4'd0; bus.req_s = 1'b0;
    bus.req_rd = 4'd0; bus.req_rn = 32'd0; bus.req_shop = 32'd0; bus.req_shc = 1'b0;
    bus.flag_we = 1'b0; bus.flag_wdata = 4'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_flags", 32'(bus.flags), 32'd0);
    check("rst_alu_op", 32'(bus.alu_op), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_cin", 32'(bus.alu_cin), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_skip", 32'(bus.skip), 32'd0);

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i], (i == 0) ? 4'b0000 : vecs[i-1].flags);

    // External flag write while idle.
    bus.flag_we = 1'b1; bus.flag_wdata = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    bus.flag_we = 1'b0;
    check("msr_idle_flags", 32'(bus.flags), 32'b0001);

    // MSR colliding with the EXEC edge of CMP 5,5: instruction update wins.
    offer(4'hE, 4'hA, 1'b0, 4'd1, 32'h5, 32'h5, 1'b0);
    @(negedge clk);
    bus.flag_we = 1'b1; bus.flag_wdata = 4'b0001;
    @(negedge clk);
    bus.flag_we = 1'b0;
    check("collide_flags", 32'(bus.flags), 32'b1100);
    check("collide_no_wb", 32'(bus.wb_valid), 32'd0);

    // Reset asserted during EXEC of ADDS aborts everything.
    offer(4'hE, 4'h4, 1'b1, 4'd9, 32'h1, 32'h7FFF_FFFF, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("abort_flags", 32'(bus.flags), 32'd0);
    check("abort_alu_op", 32'(bus.alu_op), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_wb", 32'(bus.wb_valid), 32'd0);
    end
    check("abort_flags_after", 32'(bus.flags), 32'd0);
    check("abort_ready_after", 32'(bus.req_ready), 32'd1);
    check("abort_wb_data", bus.wb_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
